// File: rtl/card_dealer_if.sv
// Bus between the BlackJack hand/score logic and the card dealer.
// The master drives the seed and the draw/shuffle requests, and the dealer answers with the issued card.
`timescale 1ns/1ps

interface card_dealer_if #(
   parameter int WIDTH = 12
);
   logic [WIDTH-1:0] i_Count;
   logic             i_Draw;
   logic             i_Shuffle;
   logic [3:0]       o_Card;
   logic [3:0]       o_Points;
   logic             o_CardValid;
   logic             o_Busy;
   logic             o_DeckEmpty;
   logic [7:0]       o_CardsLeft;

   modport master (
      output i_Count,
      output i_Draw,
      output i_Shuffle,
      input  o_Card,
      input  o_Points,
      input  o_CardValid,
      input  o_Busy,
      input  o_DeckEmpty,
      input  o_CardsLeft
   );

   modport slave (
      input  i_Count,
      input  i_Draw,
      input  i_Shuffle,
      output o_Card,
      output o_Points,
      output o_CardValid,
      output o_Busy,
      output o_DeckEmpty,
      output o_CardsLeft
   );
endinterface

// File: rtl/card_dealer.sv
// Deals cards from a finite shoe, using the free-running 2 kHz counter as a seed.
// When the seeded rank is used up, the dealer probes forward one rank per cycle until it finds one that is left.
`timescale 1ns/1ps

module card_dealer #(
   parameter int WIDTH  = 12,
   parameter int COPIES = 4
) (
   input logic         clk_2K,
   input logic         i_Reset_n,
   card_dealer_if.slave bus
);

   localparam logic [3:0] COPIES_V  = 4'(COPIES);
   localparam logic [7:0] FULL_SHOE = 8'(13 * COPIES);
   localparam logic [3:0] LAST_IDX  = 4'd12;

   typedef enum logic {IDLE, CHECK} state_t;

   state_t     state, state_next;
   logic [3:0] rem      [13];
   logic [3:0] rem_next [13];
   logic [7:0] cards_left, cards_left_next;
   logic [3:0] idx, idx_next;
   logic [3:0] card, card_next;
   logic [3:0] points, points_next;
   logic       card_valid, card_valid_next;
   logic       busy, deck_empty;
   logic [3:0] seed_idx;

   // The full-width modulo gives the starting rank, so every counter value maps into 0..12.
   assign seed_idx = 4'(bus.i_Count % WIDTH'(13));

   always_comb begin
      state_next      = state;
      rem_next        = rem;
      cards_left_next = cards_left;
      idx_next        = idx;
      card_next       = card;
      points_next     = points;
      card_valid_next = 1'b0;

      case (state)
         IDLE: begin
            if (bus.i_Shuffle) begin
               for (int i = 0; i < 13; i++) begin
                  rem_next[i] = COPIES_V;
               end
               cards_left_next = FULL_SHOE;
            end else if (bus.i_Draw && (cards_left != 8'd0)) begin
               idx_next   = seed_idx;
               state_next = CHECK;
            end
         end

         CHECK: begin
            if (rem[idx] != 4'd0) begin
               rem_next[idx]   = rem[idx] - 4'd1;
               cards_left_next = cards_left - 8'd1;
               card_next       = idx + 4'd1;
               points_next     = (idx >= 4'd9) ? 4'd10 : (idx + 4'd1);
               card_valid_next = 1'b1;
               state_next      = IDLE;
            end else begin
               idx_next = (idx == LAST_IDX) ? 4'd0 : (idx + 4'd1);
            end
         end

         default: state_next = IDLE;
      endcase
   end

   // Busy and deck-empty are registered from next-state values so that they line up with the state and the count.
   always_ff @(posedge clk_2K) begin
      if (!i_Reset_n) begin
         state      <= IDLE;
         for (int i = 0; i < 13; i++) begin
            rem[i] <= COPIES_V;
         end
         cards_left <= FULL_SHOE;
         idx        <= 4'd0;
         card       <= 4'd0;
         points     <= 4'd0;
         card_valid <= 1'b0;
         busy       <= 1'b0;
         deck_empty <= 1'b0;
      end else begin
         state      <= state_next;
         rem        <= rem_next;
         cards_left <= cards_left_next;
         idx        <= idx_next;
         card       <= card_next;
         points     <= points_next;
         card_valid <= card_valid_next;
         busy       <= (state_next == CHECK);
         deck_empty <= (cards_left_next == 8'd0);
      end
   end

   assign bus.o_Card      = card;
   assign bus.o_Points    = points;
   assign bus.o_CardValid = card_valid;
   assign bus.o_Busy      = busy;
   assign bus.o_DeckEmpty = deck_empty;
   assign bus.o_CardsLeft = cards_left;

endmodule

// File: doc/card_dealer.md
# card_dealer

Downstream consumer of the free-running 2 kHz counter in the BlackJack datapath. On each draw request it samples the counter value as a pseudo-random seed and maps it to a card rank 1..13. It tracks how many copies of each rank remain in the shoe and probes forward past exhausted ranks. It emits one card per request with its blackjack point value to the hand/score logic, and supports shuffle (refill) and deck-empty reporting.

## Interface
Parameters:
- WIDTH, 12, width of the sampled counter value (matches counter output width)
- COPIES, 4, copies of each rank in a full shoe; legal range 1..15

Ports:
- clk_2K  in  1  2 kHz system clock; all logic on rising edge
- i_Reset_n  in  1  reset, synchronous and active-low
- i_Count  in  WIDTH  live counter value used as random seed
- i_Draw  in  1  draw request, sampled each edge while idle
- i_Shuffle  in  1  refill shoe, sampled each edge while idle
- o_Card  out  4  rank of last issued card, 1 = Ace … 13 = King
- o_Points  out  4  points of o_Card: Ace = 1, 2..10 = face value, J/Q/K = 10
- o_CardValid  out  1  one-cycle pulse when o_Card/o_Points are newly valid
- o_Busy  out  1  high while a draw is being resolved
- o_DeckEmpty  out  1  high when no cards remain
- o_CardsLeft  out  8  cards remaining in shoe, 0..13*COPIES

## Operation
- State: 13 remaining-count registers rem[0..12] (4 bits each), o_CardsLeft, probe index idx (4 bits), FSM {IDLE, CHECK}.
- Reset (i_Reset_n = 0 at an edge), overriding all else: rem[all] = COPIES, o_CardsLeft = 13*COPIES, state IDLE, idx = 0, o_Card = 0, o_Points = 0, o_CardValid = 0, o_Busy = 0, o_DeckEmpty = 0.
- IDLE, priority order:
  - i_Shuffle = 1: rem[all] = COPIES, o_CardsLeft = 13*COPIES; any simultaneous i_Draw is dropped.
  - Else i_Draw = 1 and o_CardsLeft != 0: idx = i_Count mod 13 (full WIDTH-bit unsigned modulo), go CHECK.
  - Else i_Draw = 1 and o_CardsLeft == 0: request ignored, stay IDLE, no pulse.
- CHECK:
  - rem[idx] != 0: decrement rem[idx] and o_CardsLeft; o_Card = idx+1; o_Points = min(idx+1, 10); pulse o_CardValid; go IDLE.
  - rem[idx] == 0: idx = (idx == 12) ? 0 : idx+1; stay CHECK.
- i_Draw and i_Shuffle are ignored in CHECK and are not queued.
- CHECK always terminates because entry requires o_CardsLeft != 0.
- Derived outputs:
  - o_Busy = (state == CHECK), registered with the state.
  - o_DeckEmpty = (o_CardsLeft == 0).
  - o_CardValid is 0 in every cycle except the issue cycle.
- o_Card and o_Points hold their last values between issues and are unchanged by shuffle.

## Timing
- Draw sampled at edge N → CHECK from N. A hit at edge N+1 gives o_CardValid high for the single cycle after edge N+1.
- Each exhausted-rank miss adds exactly one cycle; worst case (12 misses) puts valid after edge N+13.
- o_CardsLeft and o_DeckEmpty update in the same cycle o_CardValid rises.
- Back-to-back: i_Draw held high during the o_CardValid cycle is accepted at that edge (state is IDLE), so one card issues every 2 cycles with no misses.
- Reset mid-CHECK: the pending draw is discarded, no pulse is issued, and the shoe is full on the next cycle.

## Test plan
- Reset, then idle 3 cycles → o_CardsLeft = 52, o_DeckEmpty = 0, o_CardValid = 0, o_Card = 0.
- i_Count = 0, draw → o_Card = 1, o_Points = 1 two edges later, CardsLeft = 51. i_Count = 4095, draw → o_Card = 1 (4095 mod 13 = 0), CardsLeft = 50. i_Count = 25, draw → o_Card = 13, o_Points = 10.
- Four draws with i_Count = 5 → o_Card = 6 each time. Fifth draw with i_Count = 5 → o_Card = 7, valid one cycle later than the first four.
- Draw all 52 cards with i_Draw held high → exactly 52 pulses, four of each rank, o_DeckEmpty = 1. A further draw gives no pulse and o_Busy stays 0.
- i_Draw and i_Shuffle together in IDLE on a partly used shoe → no pulse, o_CardsLeft = 52.
- Assert i_Reset_n = 0 during a CHECK probe caused by an exhausted rank → no pulse, o_CardsLeft = 52, state IDLE the following cycle.
